// File: rtl/lock_key_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Purpose  : Shared types and constants for the key loader slice.
//            Holds the loader state encoding and the frame parity polarity.
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Loader state machine encoding
  typedef enum logic [2:0] {
    LK_IDLE    = 3'd0,
    LK_SHIFT   = 3'd1,
    LK_VALID   = 3'd2,
    LK_ERR     = 3'd3,
    LK_LOCKOUT = 3'd4
  } lk_state_t;

  // A frame (key bits plus parity bit) is good when its XOR equals this value,
  // i.e. the total number of ones is even.
  localparam logic PARITY_EVEN = 1'b0;

  // Width of the consecutive-failure counter (MAX_FAIL is at most 15)
  localparam int unsigned FAIL_W = 4;

endpackage : lock_pkg
`default_nettype wire

// File: rtl/lock_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_loader_if
// Purpose  : Bundles the key-store bit stream and the key/status outputs of
//            the key loader.
// Ports    : start, ser_in, ser_valid   (master -> loader)
//            ser_ready, key_out, key_valid, busy, err, lockout
//                                         (loader -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface lock_key_loader_if #(
  parameter int unsigned KEY_W = 2
);
  logic             start;
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;
  logic             lockout;

  // Loader side
  modport slave (
    input  start, ser_in, ser_valid,
    output ser_ready, key_out, key_valid, busy, err, lockout
  );

  // Key store / controller side
  modport master (
    output start, ser_in, ser_valid,
    input  ser_ready, key_out, key_valid, busy, err, lockout
  );
endinterface : lock_key_loader_if
`default_nettype wire

// File: rtl/lock_key_loader_shreg.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_shreg
// Purpose  : Shadow register for an incoming key frame. Bit index i of the
//            frame lands in shadow[i]; the counter tracks the index of the
//            next expected bit and parks at KEY_W (the parity position).
// Ports    : clk, rst        clock, synchronous active-high reset
//            clr_i           restart a frame (counter and shadow to 0)
//            shift_i         a bit transfers this cycle
//            bit_i           transferred bit
//            shadow_o        KEY_W-bit parallel shadow contents
//            cnt_o           index of the next expected frame bit
// Revision : 1.0 - initial release
// ============================================================================
module lock_key_shreg #(
  parameter int unsigned KEY_W = 2,
  parameter int unsigned CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [KEY_W-1:0] shadow_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (shift_i && (cnt_q != CNT_W'(KEY_W))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bits are addressed by index rather than shifted, so the parity transfer
  // (index KEY_W) leaves the captured key untouched.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < int'(KEY_W); i++) begin
        if (shift_i && (cnt_q == CNT_W'(i))) begin
          shadow_q[i] <= bit_i;
        end
      end
    end
  end

  assign shadow_o = shadow_q;
  assign cnt_o    = cnt_q;

endmodule : lock_key_shreg
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_loader
// Purpose  : Loads a parity-protected key frame from the secure key store
//            over a valid/ready bit stream and drives it onto the locked
//            netlist's D inputs only once verified (zero decoy otherwise).
//            Consecutive failed loads lead to a permanent lockout.
// Ports    : clk       clock, rising edge
//            rst       synchronous active-high reset
//            bus       lock_key_loader_if.slave (start, ser_in, ser_valid,
//                      ser_ready, key_out, key_valid, busy, err, lockout)
// Options  : KEY_LOADER_TIMEOUT_EN - adds an inter-bit watchdog in SHIFT;
//            TIMEOUT idle cycles count as a failed load.
// Revision : 1.0 - initial release
// ============================================================================
module lock_key_loader
  import lock_pkg::*;
#(
  parameter int unsigned KEY_W    = 2,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  lock_key_loader_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  // Elaboration-time range guard on the configuration
  if ((KEY_W < 1) || (KEY_W > 64) || (MAX_FAIL < 1) || (MAX_FAIL > 15) ||
      (TIMEOUT < 1)) begin : g_param_check
    $error("lock_key_loader: parameter out of legal range");
  end

  lk_state_t         state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [FAIL_W-1:0] fail_q, fail_d;

  logic [KEY_W-1:0]  w_shadow;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_xfer;
  logic              w_parity_xfer;
  logic              w_par_ok;
  logic              w_enter_shift;
  logic              w_fail;
  logic              w_timeout;
  logic [FAIL_W-1:0] w_fail_inc;

  // ser_ready depends on state only, so a transfer is simply valid in SHIFT
  assign w_xfer        = (state_q == LK_SHIFT) && bus.ser_valid;
  assign w_parity_xfer = w_xfer && (w_cnt == CNT_W'(KEY_W));
  assign w_par_ok      = ((^w_shadow) ^ bus.ser_in) == PARITY_EVEN;
  assign w_fail_inc    = (fail_q >= FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

  lock_key_shreg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_enter_shift),
    .shift_i  (w_xfer),
    .bit_i    (bus.ser_in),
    .shadow_o (w_shadow),
    .cnt_o    (w_cnt)
  );

`ifdef KEY_LOADER_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_q;

  // Counts idle SHIFT cycles since the last transfer (or since entry).
  // Expiry is the TIMEOUT-th consecutive idle cycle.
  assign w_timeout = (state_q == LK_SHIFT) && !w_xfer &&
                     (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_q != LK_SHIFT) || w_xfer) begin
      wd_q <= '0;
    end else if (!w_timeout) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LK_IDLE;
      key_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    fail_d        = fail_q;
    w_enter_shift = 1'b0;
    w_fail        = 1'b0;

    case (state_q)
      LK_IDLE, LK_VALID, LK_ERR: begin
        if (bus.start) begin
          state_d       = LK_SHIFT;
          w_enter_shift = 1'b1;
        end
      end
      LK_SHIFT: begin
        if (w_parity_xfer) begin
          if (w_par_ok) begin
            state_d = LK_VALID;
            key_d   = w_shadow;
            fail_d  = '0;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
        if (w_fail) begin
          fail_d  = w_fail_inc;
          state_d = (w_fail_inc >= FAIL_W'(MAX_FAIL)) ? LK_LOCKOUT : LK_ERR;
        end
      end
      LK_LOCKOUT: begin
        state_d = LK_LOCKOUT;
      end
      default: begin
        state_d = LK_IDLE;
      end
    endcase
  end

  // The key register is gated by VALID so shadow or stale keys never leak.
  assign bus.ser_ready = (state_q == LK_SHIFT);
  assign bus.busy      = (state_q == LK_SHIFT);
  assign bus.key_valid = (state_q == LK_VALID);
  assign bus.key_out   = (state_q == LK_VALID) ? key_q : '0;
  assign bus.err       = (state_q == LK_ERR) || (state_q == LK_LOCKOUT);
  assign bus.lockout   = (state_q == LK_LOCKOUT);

endmodule : lock_key_loader
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_key_loader
// Purpose  : Self-checking directed bench for lock_key_loader with KEY_W=2,
//            MAX_FAIL=3, TIMEOUT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_key_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lock_key_loader_if #(.KEY_W(2)) bus ();

  lock_key_loader #(
    .KEY_W    (2),
    .MAX_FAIL (3),
    .TIMEOUT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse start, then stream f[0], f[1], f[2] (parity) back to back.
  task automatic send_frame(input logic [2:0] f);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = f[i];
      tick();
    end
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.key_out, bus.key_valid, bus.ser_ready, bus.busy, bus.err, bus.lockout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got key=%b kv=%b rdy=%b busy=%b err=%b lock=%b want all 0",
               bus.key_out, bus.key_valid, bus.ser_ready, bus.busy, bus.err, bus.lockout);
    end
  endtask

  task automatic test_valid_frame();
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b0;
    tick();
    bus.ser_in = 1'b1;
    tick();
    // Both key bits captured, parity pending: nothing must be visible yet
    checks++;
    if ({bus.key_out, bus.key_valid, bus.busy, bus.ser_ready} !== 5'b00011) begin
      failures++;
      $display("FAIL valid_midframe: got key=%b kv=%b busy=%b rdy=%b want key=00 kv=0 busy=1 rdy=1",
               bus.key_out, bus.key_valid, bus.busy, bus.ser_ready);
    end
    bus.ser_in = 1'b1;
    tick();
    bus.ser_valid = 1'b0;
    checks++;
    if ({bus.key_out, bus.key_valid, bus.err, bus.busy} !== 5'b10100) begin
      failures++;
      $display("FAIL valid_result: got key=%b kv=%b err=%b busy=%b want key=10 kv=1 err=0 busy=0",
               bus.key_out, bus.key_valid, bus.err, bus.busy);
    end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_frame(3'b111);
    checks++;
    if ({bus.err, bus.key_out, bus.key_valid, bus.lockout} !== 5'b10000) begin
      failures++;
      $display("FAIL bad_parity: got err=%b key=%b kv=%b lock=%b want err=1 key=00 kv=0 lock=0",
               bus.err, bus.key_out, bus.key_valid, bus.lockout);
    end
    // Good frame 1,1,0 clears err and the fail count
    send_frame(3'b011);
    checks++;
    if ({bus.key_out, bus.key_valid, bus.err} !== 4'b1110) begin
      failures++;
      $display("FAIL recover_good: got key=%b kv=%b err=%b want key=11 kv=1 err=0",
               bus.key_out, bus.key_valid, bus.err);
    end
    // Two more failures: count is 2, not 3, so no lockout
    send_frame(3'b111);
    send_frame(3'b111);
    checks++;
    if ({bus.err, bus.lockout} !== 2'b10) begin
      failures++;
      $display("FAIL fail_count_reset: got err=%b lock=%b want err=1 lock=0",
               bus.err, bus.lockout);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    send_frame(3'b111);
    send_frame(3'b111);
    checks++;
    if (bus.lockout !== 1'b0) begin
      failures++;
      $display("FAIL lockout_early: got lock=%b want 0 after 2 failures", bus.lockout);
    end
    send_frame(3'b111);
    checks++;
    if ({bus.lockout, bus.err, bus.ser_ready, bus.key_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL lockout_enter: got lock=%b err=%b rdy=%b kv=%b want lock=1 err=1 rdy=0 kv=0",
               bus.lockout, bus.err, bus.ser_ready, bus.key_valid);
    end
    send_frame(3'b110);
    checks++;
    if ({bus.lockout, bus.key_out, bus.ser_ready, bus.busy} !== 5'b10000) begin
      failures++;
      $display("FAIL lockout_sticky: got lock=%b key=%b rdy=%b busy=%b want lock=1 key=00 rdy=0 busy=0",
               bus.lockout, bus.key_out, bus.ser_ready, bus.busy);
    end
    do_reset();
    checks++;
    if ({bus.lockout, bus.err} !== 2'b00) begin
      failures++;
      $display("FAIL lockout_rst: got lock=%b err=%b want 0 0", bus.lockout, bus.err);
    end
  endtask

  task automatic test_reload_reset();
    do_reset();
    send_frame(3'b110);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.key_out, bus.key_valid, bus.busy, bus.err} !== 5'b00010) begin
      failures++;
      $display("FAIL reload_clear: got key=%b kv=%b busy=%b err=%b want key=00 kv=0 busy=1 err=0",
               bus.key_out, bus.key_valid, bus.busy, bus.err);
    end
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    tick();
    bus.ser_valid = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.key_out, bus.key_valid, bus.ser_ready, bus.busy, bus.err, bus.lockout} !== 7'b0) begin
      failures++;
      $display("FAIL midframe_rst: got key=%b kv=%b rdy=%b busy=%b err=%b lock=%b want all 0",
               bus.key_out, bus.key_valid, bus.ser_ready, bus.busy, bus.err, bus.lockout);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] vld;
    logic [4:0] dat;
    vld = 5'b11001;   // index 0 first: 1,0,0,1,1
    dat = 5'b10001;   // bits 1,x,x,0,1 with x driven as 0
    do_reset();
    // start and ser_valid together in IDLE: the bit must not be consumed
    bus.start     = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ser_valid = vld[i];
      bus.ser_in    = dat[i];
      bus.start     = (i == 2);   // start mid-frame must not restart the load
      tick();
      if (i == 2) begin
        checks++;
        if ({bus.busy, bus.ser_ready, bus.key_valid} !== 3'b110) begin
          failures++;
          $display("FAIL bp_stall: got busy=%b rdy=%b kv=%b want busy=1 rdy=1 kv=0",
                   bus.busy, bus.ser_ready, bus.key_valid);
        end
      end
    end
    bus.ser_valid = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if ({bus.key_out, bus.key_valid, bus.err} !== 4'b0110) begin
      failures++;
      $display("FAIL bp_result: got key=%b kv=%b err=%b want key=01 kv=1 err=0",
               bus.key_out, bus.key_valid, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    // Continues from VALID with key 01: stray bits in VALID are ignored
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    tick();
    tick();
    bus.ser_valid = 1'b0;
    checks++;
    if ({bus.key_out, bus.key_valid, bus.ser_ready} !== 4'b0110) begin
      failures++;
      $display("FAIL ignore_valid_idle: got key=%b kv=%b rdy=%b want key=01 kv=1 rdy=0",
               bus.key_out, bus.key_valid, bus.ser_ready);
    end
    send_frame(3'b011);
    checks++;
    if ({bus.key_out, bus.key_valid} !== 3'b111) begin
      failures++;
      $display("FAIL back_to_back: got key=%b kv=%b want key=11 kv=1",
               bus.key_out, bus.key_valid);
    end
  endtask

`ifdef KEY_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    tick();
    bus.ser_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.err, bus.busy} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_early: got err=%b busy=%b want err=0 busy=1 after 3 idle",
               bus.err, bus.busy);
    end
    tick();
    checks++;
    if ({bus.err, bus.busy, bus.lockout} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_fire: got err=%b busy=%b lock=%b want err=1 busy=0 lock=0",
               bus.err, bus.busy, bus.lockout);
    end
    // Timeout counted as failure 1; two parity failures reach the limit
    send_frame(3'b111);
    send_frame(3'b111);
    checks++;
    if (bus.lockout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_count: got lock=%b want 1", bus.lockout);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      failures++;
      $display("FAIL no_timeout: got busy=%b err=%b want busy=1 err=0", bus.busy, bus.err);
    end
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
    test_reset();
    test_valid_frame();
    test_bad_parity();
    test_lockout();
    test_reload_reset();
    test_backpressure();
    test_back_to_back();
`ifdef KEY_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lock_key_loader
`default_nettype wire
